// File: rtl/sc_sng_bank.sv
// Bank of N stochastic number generators sharing one maximal-length LFSR.
// Each lane compares a lane-specific rotation of the LFSR state against its operand, once per frame cycle.
module sc_sng_bank #(
    parameter int             K    = 3,
    parameter int             N    = 2**K,
    parameter int             W    = 8,
    parameter logic [W-1:0]   SEED = 8'h01
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [N*W-1:0]   load_data,
    input  logic             abort,
    output logic [N-1:0]     dout,
    output logic             dout_valid,
    output logic             dout_last,
    output logic             busy
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Fibonacci tap mask per width; bit t-1 set for tap x^t.
    function automatic logic [W-1:0] tap_mask(input int w);
        logic [15:0] m;
        case (w)
            32'sd4:  m = 16'h000C;
            32'sd5:  m = 16'h0014;
            32'sd6:  m = 16'h0030;
            32'sd7:  m = 16'h0060;
            32'sd8:  m = 16'h00B8;
            32'sd9:  m = 16'h0110;
            32'sd10: m = 16'h0240;
            32'sd11: m = 16'h0500;
            32'sd12: m = 16'h0829;
            32'sd13: m = 16'h100D;
            32'sd14: m = 16'h2015;
            32'sd15: m = 16'h6000;
            32'sd16: m = 16'hD008;
            default: m = 16'h0000;
        endcase
        return m[W-1:0];
    endfunction

    localparam logic [W-1:0] TAPS     = tap_mask(W);
    localparam logic [W-1:0] ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] SEED_EFF = (SEED == {W{1'b0}}) ? ONE_W : SEED;
    localparam logic [W-1:0] CNT_MAX  = {{(W-1){1'b1}}, 1'b0};

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
        return {s[W-2:0], ^(s & TAPS)};
    endfunction

    // Rotation is a bijection on nonzero states, so every lane still sees each value once per frame.
    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int amt);
        logic [W-1:0] r;
        r = x;
        for (int j = 0; j < W; j++) begin
            r[(j + amt) % W] = x[j];
        end
        return r;
    endfunction

    logic [0:0]     state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   lfsr_q, lfsr_d;
    logic [N*W-1:0] op_q, op_d;
    logic [N-1:0]   dout_q, dout_d;
    logic           dout_valid_q, dout_valid_d;
    logic           dout_last_q, dout_last_d;
    logic           busy_q, busy_d;

    logic           is_last_s;
    logic           load_ready_s;
    logic           accept_s;

    // Handshake: ready in IDLE, or in the final frame cycle unless an abort is pending.
    always_comb begin
        is_last_s    = (state_q == ST_RUN) && (cnt_q == CNT_MAX);
        load_ready_s = 1'b0;
        if (state_q == ST_IDLE) begin
            load_ready_s = 1'b1;
        end else if (is_last_s && !abort) begin
            load_ready_s = 1'b1;
        end else begin
            load_ready_s = 1'b0;
        end
        accept_s = load_valid && load_ready_s;
    end

    // Frame sequencing: operand capture, counter, LFSR stepping and abort handling.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lfsr_d  = lfsr_q;
        op_d    = op_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = ST_RUN;
                    cnt_d   = {W{1'b0}};
                    op_d    = load_data;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = {W{1'b0}};
                    lfsr_d  = SEED_EFF;
                end else begin
                    lfsr_d = lfsr_step(lfsr_q);
                    if (is_last_s) begin
                        cnt_d = {W{1'b0}};
                        if (accept_s) begin
                            state_d = ST_RUN;
                            op_d    = load_data;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + ONE_W;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {W{1'b0}};
                lfsr_d  = SEED_EFF;
            end
        endcase
    end

    // Output bits are computed from next-state values so the registered outputs track the state registers.
    always_comb begin
        dout_valid_d = (state_d == ST_RUN);
        busy_d       = (state_d == ST_RUN);
        dout_last_d  = dout_valid_d && (cnt_d == CNT_MAX);
        dout_d       = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            dout_d[i] = dout_valid_d && (rotl(lfsr_d, i % W) <= op_d[i*W +: W]);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {W{1'b0}};
            lfsr_q       <= SEED_EFF;
            op_q         <= {(N*W){1'b0}};
            dout_q       <= {N{1'b0}};
            dout_valid_q <= 1'b0;
            dout_last_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lfsr_q       <= lfsr_d;
            op_q         <= op_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_last_q  <= dout_last_d;
            busy_q       <= busy_d;
        end
    end

    assign load_ready = load_ready_s;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_last  = dout_last_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_sc_sng_bank.sv
// Scoreboard bench for sc_sng_bank: stimulus queues expected frame summaries, a negedge monitor checks them.
module tb_sc_sng_bank;

    localparam int K = 3;
    localparam int N = 8;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           load_valid;
    logic [N*W-1:0] load_data;
    logic           abort;
    logic           load_ready;
    logic [N-1:0]   dout;
    logic           dout_valid;
    logic           dout_last;
    logic           busy;

    logic           dec_load_ready;
    logic [N-1:0]   dec_dout;
    logic           dec_dout_valid;
    logic           dec_dout_last;
    logic           dec_busy;

    always #5 clk = ~clk;

    sc_sng_bank #(.K(K), .N(N), .W(W), .SEED(8'h01)) u_dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .abort(abort), .dout(dout), .dout_valid(dout_valid),
        .dout_last(dout_last), .busy(busy)
    );

    sc_sng_bank #(.K(K), .N(N), .W(W), .SEED(8'hA5)) u_dec (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(dec_load_ready),
        .load_data(load_data), .abort(abort), .dout(dec_dout), .dout_valid(dec_dout_valid),
        .dout_last(dec_dout_last), .busy(dec_busy)
    );

    typedef struct packed {
        logic [N-1:0][8:0] ones;
        logic [8:0]        len;
        logic              aborted;
        logic              next_cont;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t make_exp(input logic [N*W-1:0] d, input logic ab, input int len, input logic nc);
        exp_t e;
        for (int i = 0; i < N; i++) e.ones[i] = {1'b0, d[i*W +: W]};
        e.len       = len[8:0];
        e.aborted   = ab;
        e.next_cont = nc;
        return e;
    endfunction

    // Monitor: accumulate per-lane ones while dout_valid, compare at frame end.
    int   mon_len = 0;
    int   mon_ones[N];
    bit   cont_pending = 1'b0;
    bit   cont_exp = 1'b0;
    exp_t mon_e;

    always @(negedge clk) begin
        if (reset) begin
            mon_len = 0;
            cont_pending = 1'b0;
            for (int i = 0; i < N; i++) mon_ones[i] = 0;
        end else begin
            if (cont_pending) begin
                check("valid_after_last", int'(dout_valid), int'(cont_exp));
                cont_pending = 1'b0;
            end
            if (dout_valid) begin
                mon_len++;
                for (int i = 0; i < N; i++) mon_ones[i] += int'(dout[i]);
                if (dout_last) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 1, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("frame_len", mon_len, int'(mon_e.len));
                        check("frame_completed", 0, int'(mon_e.aborted));
                        for (int i = 0; i < N; i++)
                            check($sformatf("lane%0d_ones", i), mon_ones[i], int'(mon_e.ones[i]));
                        cont_pending = 1'b1;
                        cont_exp = mon_e.next_cont;
                    end
                    mon_len = 0;
                    for (int i = 0; i < N; i++) mon_ones[i] = 0;
                end
            end else if (mon_len > 0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_cut_frame", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("abort_len", mon_len, int'(mon_e.len));
                    check("frame_aborted", 1, int'(mon_e.aborted));
                    check("abort_dout", int'(dout), 0);
                    check("abort_last", int'(dout_last), 0);
                    check("abort_load_ready", int'(load_ready), 1);
                end
                mon_len = 0;
                for (int i = 0; i < N; i++) mon_ones[i] = 0;
            end
        end
    end

    task automatic do_load(input logic [N*W-1:0] data, input exp_t e);
        bit ok;
        ok = 1'b0;
        load_valid = 1'b1;
        load_data  = data;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (load_ready) begin
                ok = 1'b1;
                exp_q.push_back(e);
                break;
            end
        end
        if (!ok) check("load_accept_timeout", 0, 1);
        @(posedge clk);
        #1 load_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !dout_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*W-1:0] d80, d40, dmix;
        int and_cnt;
        d80  = {N{8'h80}};
        d40  = {N{8'h40}};
        dmix = {8'h02, 8'hFE, 8'hC8, 8'h64, 8'h11, 8'hFF, 8'h01, 8'h00};

        // Reset held two cycles with a load offered
        reset = 1'b1; abort = 1'b0; load_valid = 1'b1; load_data = {(N*W){1'b1}};
        for (int r = 0; r < 2; r++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_dout", int'(dout), 0);
            check("rst_valid", int'(dout_valid), 0);
            check("rst_last", int'(dout_last), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_load_ready", int'(load_ready), 1);
        end
        reset = 1'b0; load_valid = 1'b0;
        @(negedge clk);
        check("post_rst_valid", int'(dout_valid), 0);
        check("post_rst_busy", int'(busy), 0);
        @(posedge clk);
        #1;

        // Half scale
        do_load(d80, make_exp(d80, 1'b0, 255, 1'b0));
        wait_idle();
        check("half_busy_after", int'(busy), 0);

        // Extremes and mix
        do_load(dmix, make_exp(dmix, 1'b0, 255, 1'b0));
        wait_idle();

        // Back-to-back: second load accepted in the last cycle
        do_load(d80, make_exp(d80, 1'b0, 255, 1'b1));
        do_load(d40, make_exp(d40, 1'b0, 255, 1'b0));
        wait_idle();

        // Abort during valid cycle 100, then a fresh frame
        do_load(d40, make_exp(d40, 1'b1, 100, 1'b0));
        repeat (99) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        wait_idle();
        do_load(d40, make_exp(d40, 1'b0, 255, 1'b0));
        wait_idle();

        // Abort together with a load in the last cycle
        do_load(d80, make_exp(d80, 1'b0, 255, 1'b0));
        repeat (254) @(posedge clk);
        #1 abort = 1'b1; load_valid = 1'b1; load_data = d40;
        @(negedge clk);
        check("abort_last_load_ready", int'(load_ready), 0);
        check("abort_last_is_last", int'(dout_last), 1);
        @(posedge clk);
        #1 abort = 1'b0; load_valid = 1'b0;
        @(negedge clk);
        check("abort_last_idle_valid", int'(dout_valid), 0);
        check("abort_last_idle_busy", int'(busy), 0);
        @(negedge clk);
        check("abort_last_no_capture", int'(dout_valid), 0);
        @(posedge clk);
        #1;

        // Decorrelation between SEED=1 and SEED=A5 lanes
        and_cnt = 0;
        do_load(d80, make_exp(d80, 1'b0, 255, 1'b0));
        for (int k = 0; k < 255; k++) begin
            @(negedge clk);
            and_cnt += int'(dout[0] & dec_dout[0] & dec_dout_valid);
        end
        checks++;
        if (and_cnt < 52 || and_cnt > 76) begin
            errors++;
            $display("FAIL decorrelation: AND count %0d, expected 52..76", and_cnt);
        end
        wait_idle();

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
